hpdmc_wrdatapath: RTL and testbench
===================================

Name: hpdmc_wrdatapath

Overview:
Write-direction datapath of the DDR16 controller. It is the transmit counterpart of the input DDR capture bank. On each WRITE command issued by the command scheduler, it fetches burst data from the data source one beat per cycle. It presents rise/fall halves, masks and DQS/DQ output enables to the output DDR register bank, with DQS preamble and postamble sequencing. Sits between the FML write-data side and the pad-level ODDR bank.

Parameters:
DQ_WIDTH, 16, DDR data pins; one sys_clk beat carries 2*DQ_WIDTH bits.
BURST_CYCLES, 4, sys_clk beats per write burst (DDR burst length = 2*BURST_CYCLES); legal 2..16.

Ports:
sys_clk  in  1  system clock; all state changes on rising edge.
sys_rst  in  1  synchronous reset, active-high.
write  in  1  one-cycle pulse, coincides with WRITE command on the bus.
busy  out  1  a write pulse now would be rejected.
write_data  in  2*DQ_WIDTH  beat data; [2W-1:W] is the rise half, [W-1:0] is the fall half.
write_mask  in  DQ_WIDTH/4  byte masks, same split; 1 = masked.
data_ack  out  1  write_data/write_mask consumed at this edge.
dq_rise, dq_fall  out  DQ_WIDTH each  to ODDR D0/D1.
dm_rise, dm_fall  out  DQ_WIDTH/8 each  to DM ODDR.
dq_oe  out  1  DQ/DM output enable.
dqs_rise, dqs_fall  out  1 each  DQS ODDR data.
dqs_oe  out  1  DQS output enable.

Behaviour:
- States: IDLE, PREAMBLE, BURST (beat counter cnt, 0..BURST_CYCLES-1), POSTAMBLE. All outputs are registered except busy and data_ack, which are decoded from state.
- Reset values: state IDLE, cnt 0, dq_rise/dq_fall 0, dm_rise/dm_fall all ones, dq_oe 0, dqs_rise/dqs_fall 0, dqs_oe 0. Combinationally, data_ack 0 and busy 0 while in IDLE.
- IDLE: write=1 -> PREAMBLE.
- PREAMBLE, one cycle: dqs_oe=1, dqs_rise=dqs_fall=0, dq_oe=0. Moves to BURST with cnt=0.
- BURST: dq_oe=1, dqs_oe=1, dqs_rise=1, dqs_fall=0. dq_* and dm_* carry the beat registered at the previous edge. cnt increments each cycle.
- At cnt=BURST_CYCLES-1:
  - write=1 -> seamless: stays in BURST with cnt=0. No postamble or preamble; DQS keeps toggling.
  - write=0 -> POSTAMBLE.
- POSTAMBLE, one cycle: dqs_oe=1, dqs_rise=dqs_fall=0, dq_oe=0, dm all ones.
  - write=1 -> PREAMBLE; dqs_oe stays high throughout.
  - write=0 -> IDLE.
- data_ack is asserted:
  - in PREAMBLE;
  - in BURST with cnt<BURST_CYCLES-1;
  - in BURST with cnt=BURST_CYCLES-1 when write=1.
  The source must hold valid data whenever data_ack is high; the block has no stall. On each data_ack edge, dq_rise/dq_fall/dm_* are loaded from the rise/fall halves. Outside BURST they return to 0 and all-ones.
- Latency: write at cycle T -> first data beat on dq_* at T+2. A burst emits exactly BURST_CYCLES beats and BURST_CYCLES acks.
- busy=1 in PREAMBLE, and in BURST with cnt<BURST_CYCLES-1. A write while busy is ignored: no state change and no extra ack.
- sys_rst mid-burst: next edge forces reset values, with dq_oe/dqs_oe low immediately. No postamble is generated; the scheduler must reissue.

Optional Feature:
HPDMC_WRDATAPATH_ERRCNT_EN:
- Defined: adds output port err_count [15:0]. It is a saturating count of write pulses ignored while busy, cleared by sys_rst, and holds at 16'hFFFF.
- Undefined: port absent and no counter logic; ignored writes are silent.

Decomposition:
- Shared package hpdmc_ddr_pkg:
  - state encodings (IDLE=2'd0, PREAMBLE=2'd1, BURST=2'd2, POSTAMBLE=2'd3);
  - DQS pattern constants;
  - DM_ALL_MASKED.
- Natural sub-module hpdmc_wrdatapath_seq: the FSM plus beat counter, outputting state, cnt, data_ack and busy. The top holds the data/mask registers and the enable registers.

Test Plan:
- Single write, data beats 32'hA5A5_0001..0004, mask 0: dqs_oe rises at T+1; dq_oe high T+2..T+5; dq_rise=16'hA5A5 and dq_fall=16'h0001..0004 in order; postamble at T+6; IDLE at T+7.
- Seamless: second write at cnt=3 -> 8 contiguous beats and 8 acks; dqs_rise never drops; exactly one preamble and one postamble.
- Write during POSTAMBLE: dqs_oe never deasserts; next data appears 2 cycles after the pulse.
- Write at cnt=1 (busy=1): ignored; exactly 4 beats; with HPDMC_WRDATAPATH_ERRCNT_EN, err_count=1.
- Mask beat write_mask=4'b0110: dm_rise=2'b01, dm_fall=2'b10 on that beat; dm all ones outside BURST.
- sys_rst asserted at cnt=2: next cycle all outputs at reset values and state IDLE; a following write yields a clean 4-beat burst.

Source files
------------

// File: rtl/hpdmc_ddr_pkg.sv
// Shared definitions for the HPDMC DDR16 datapath blocks.
//   - wr_state_e    : write-path FSM encoding (IDLE/PREAMBLE/BURST/POSTAMBLE)
//   - DQS_*         : DQS ODDR data pattern while bursting and while quiet
//   - DM_ALL_MASKED : data-mask value that blocks every byte lane
package hpdmc_ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PREAMBLE  = 2'd1,
    ST_BURST     = 2'd2,
    ST_POSTAMBLE = 2'd3
  } wr_state_e;

  // During a burst DQS is driven 1 on the rising half and 0 on the falling
  // half, so the strobe toggles once per DDR bit. Outside a burst (preamble,
  // postamble) it is held low while still enabled.
  localparam logic DQS_RISE_BURST = 1'b1;
  localparam logic DQS_FALL_BURST = 1'b0;
  localparam logic DQS_RISE_QUIET = 1'b0;
  localparam logic DQS_FALL_QUIET = 1'b0;

  // Wide enough for DQ_WIDTH up to 128; users take the low DQ_WIDTH/8 bits.
  localparam logic [15:0] DM_ALL_MASKED = 16'hFFFF;

endpackage

// File: rtl/hpdmc_wrdatapath_seq.sv
// Write-path sequencer: FSM plus beat counter.
// Ports:
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   write_i              : WRITE command pulse
//   state_o              : current FSM state (also the debug view)
//   cnt_o                : beat counter within BURST
//   data_ack_o           : source beat consumed at this edge
//   busy_o               : a write pulse now would be ignored
// Handshake: data_ack_o is a consume strobe with no back-pressure; the source
// must present valid data in every cycle where data_ack_o is high.
module hpdmc_wrdatapath_seq
  import hpdmc_ddr_pkg::*;
#(
  parameter int BURST_CYCLES = 4,
  parameter int CW           = (BURST_CYCLES > 2) ? $clog2(BURST_CYCLES) : 1
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          write_i,
  output wr_state_e     state_o,
  output logic [CW-1:0] cnt_o,
  output logic          data_ack_o,
  output logic          busy_o
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_CYCLES - 1);

  wr_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_beat;

  assign last_beat = (cnt_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (write_i) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        state_d = ST_BURST;
        cnt_d   = '0;
      end
      ST_BURST: begin
        if (last_beat) begin
          // A write on the last beat chains a new burst with no gap.
          cnt_d = '0;
          if (!write_i) state_d = ST_POSTAMBLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_POSTAMBLE: begin
        state_d = write_i ? ST_PREAMBLE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ack exactly when the next state is BURST: the top loads the beat then.
  assign data_ack_o = (state_q == ST_PREAMBLE) ||
                      ((state_q == ST_BURST) && (!last_beat || write_i));
  assign busy_o     = (state_q == ST_PREAMBLE) ||
                      ((state_q == ST_BURST) && !last_beat);

  assign state_o = state_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/hpdmc_wrdatapath.sv
// Write-direction datapath of the DDR16 controller. Fetches one beat per
// sys_clk on each accepted WRITE and drives the output DDR register bank
// with data/mask halves, DQ/DQS enables and DQS pre/postamble.
// Ports:
//   sys_clk, sys_rst       : clock, synchronous active-high reset
//   write / busy           : WRITE pulse in, reject indication out
//   write_data, write_mask : source beat ({rise, fall} halves)
//   data_ack               : beat consumed at this edge
//   dq_rise/fall, dm_rise/fall, dq_oe : DQ/DM ODDR data and enable
//   dqs_rise/fall, dqs_oe  : DQS ODDR data and enable
//   err_count              : only with HPDMC_WRDATAPATH_ERRCNT_EN defined;
//                            saturating count of writes ignored while busy
// Macro: HPDMC_WRDATAPATH_ERRCNT_EN
module hpdmc_wrdatapath
  import hpdmc_ddr_pkg::*;
#(
  parameter int DQ_WIDTH     = 16,
  parameter int BURST_CYCLES = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  write,
  output logic                  busy,
  input  logic [2*DQ_WIDTH-1:0] write_data,
  input  logic [DQ_WIDTH/4-1:0] write_mask,
  output logic                  data_ack,
  output logic [DQ_WIDTH-1:0]   dq_rise,
  output logic [DQ_WIDTH-1:0]   dq_fall,
  output logic [DQ_WIDTH/8-1:0] dm_rise,
  output logic [DQ_WIDTH/8-1:0] dm_fall,
  output logic                  dq_oe,
  output logic                  dqs_rise,
  output logic                  dqs_fall,
  output logic                  dqs_oe
`ifdef HPDMC_WRDATAPATH_ERRCNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  localparam int DMW = DQ_WIDTH / 8;
  localparam int CW  = (BURST_CYCLES > 2) ? $clog2(BURST_CYCLES) : 1;
  localparam logic [DMW-1:0] DM_OFF = DM_ALL_MASKED[DMW-1:0];

  wr_state_e     state;
  logic [CW-1:0] seq_cnt_unused;  // beat counter tap, for debug probing
  logic          ack;
  logic          busy_w;

  hpdmc_wrdatapath_seq #(
    .BURST_CYCLES (BURST_CYCLES),
    .CW           (CW)
  ) u_seq (
    .sys_clk_i  (sys_clk),
    .sys_rst_i  (sys_rst),
    .write_i    (write),
    .state_o    (state),
    .cnt_o      (seq_cnt_unused),
    .data_ack_o (ack),
    .busy_o     (busy_w)
  );

  assign data_ack = ack;
  assign busy     = busy_w;

  logic [DQ_WIDTH-1:0] dq_rise_q, dq_fall_q;
  logic [DMW-1:0]      dm_rise_q, dm_fall_q;
  logic                dq_oe_q, dqs_oe_q, dqs_rise_q, dqs_fall_q;
  logic                dq_oe_d, dqs_oe_d;

  // The next state is BURST exactly when a beat is acked, so the ack doubles
  // as the next-cycle DQ enable. DQS stays enabled for every non-IDLE state,
  // including the postamble that follows the last beat.
  assign dq_oe_d  = ack;
  assign dqs_oe_d = ack || (state == ST_BURST) ||
                    (write && ((state == ST_IDLE) || (state == ST_POSTAMBLE)));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dq_rise_q  <= '0;
      dq_fall_q  <= '0;
      dm_rise_q  <= DM_OFF;
      dm_fall_q  <= DM_OFF;
      dq_oe_q    <= 1'b0;
      dqs_oe_q   <= 1'b0;
      dqs_rise_q <= DQS_RISE_QUIET;
      dqs_fall_q <= DQS_FALL_QUIET;
    end else begin
      dq_oe_q    <= dq_oe_d;
      dqs_oe_q   <= dqs_oe_d;
      dqs_rise_q <= dq_oe_d ? DQS_RISE_BURST : DQS_RISE_QUIET;
      dqs_fall_q <= dq_oe_d ? DQS_FALL_BURST : DQS_FALL_QUIET;
      if (ack) begin
        dq_rise_q <= write_data[2*DQ_WIDTH-1:DQ_WIDTH];
        dq_fall_q <= write_data[DQ_WIDTH-1:0];
        dm_rise_q <= write_mask[2*DMW-1:DMW];
        dm_fall_q <= write_mask[DMW-1:0];
      end else begin
        dq_rise_q <= '0;
        dq_fall_q <= '0;
        dm_rise_q <= DM_OFF;
        dm_fall_q <= DM_OFF;
      end
    end
  end

  assign dq_rise  = dq_rise_q;
  assign dq_fall  = dq_fall_q;
  assign dm_rise  = dm_rise_q;
  assign dm_fall  = dm_fall_q;
  assign dq_oe    = dq_oe_q;
  assign dqs_oe   = dqs_oe_q;
  assign dqs_rise = dqs_rise_q;
  assign dqs_fall = dqs_fall_q;

`ifdef HPDMC_WRDATAPATH_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (write && busy_w && (err_count_q != 16'hFFFF))
      err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) err_count_q <= '0;
    else         err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_hpdmc_wrdatapath.sv
module tb_hpdmc_wrdatapath;

  localparam int B    = 4;
  localparam int MAXC = 2048;

  // clock / reset / DUT signals
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        write = 1'b0;
  logic        busy;
  logic [31:0] write_data = '0;
  logic [3:0]  write_mask = '0;
  logic        data_ack;
  logic [15:0] dq_rise, dq_fall;
  logic [1:0]  dm_rise, dm_fall;
  logic        dq_oe, dqs_rise, dqs_fall, dqs_oe;
`ifdef HPDMC_WRDATAPATH_ERRCNT_EN
  logic [15:0] err_count;
`endif

  always #5 sys_clk = ~sys_clk;

  hpdmc_wrdatapath #(.DQ_WIDTH(16), .BURST_CYCLES(B)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .write      (write),
    .busy       (busy),
    .write_data (write_data),
    .write_mask (write_mask),
    .data_ack   (data_ack),
    .dq_rise    (dq_rise),
    .dq_fall    (dq_fall),
    .dm_rise    (dm_rise),
    .dm_fall    (dm_fall),
    .dq_oe      (dq_oe),
    .dqs_rise   (dqs_rise),
    .dqs_fall   (dqs_fall),
    .dqs_oe     (dqs_oe)
`ifdef HPDMC_WRDATAPATH_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  // Reference model: a per-cycle timeline of what each output must be,
  // filled in burst-by-burst when a write is accepted.
  bit          e_ack  [MAXC];
  bit          e_busy [MAXC];
  bit          e_oe   [MAXC];
  bit          e_dqsoe[MAXC];
  logic [31:0] wd     [MAXC];
  logic [3:0]  wm     [MAXC];
  int          cyc = 0;
  int          err_m = 0;
  bit          chk_en = 1'b0;
  int          total = 0;
  int          passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s cyc=%0d got %h expected %h", tag, cyc, obs, expv);
  endtask

  task automatic mark(input int c, input bit ack, input bit bsy, input bit oe, input bit dqs);
    if (c < MAXC) begin
      if (ack) e_ack[c]   = 1'b1;
      if (bsy) e_busy[c]  = 1'b1;
      if (oe)  e_oe[c]    = 1'b1;
      if (dqs) e_dqsoe[c] = 1'b1;
    end
  endtask

  // Accepted write at cycle t: from idle/postamble it costs one preamble
  // cycle; on the final beat of a burst it chains seamlessly.
  task automatic model_write(input int t);
    if (e_busy[t]) begin
      if (err_m < 65535) err_m++;
    end else if (e_oe[t]) begin
      mark(t, 1, 0, 0, 0);
      for (int k = 1; k <= B; k++) begin
        mark(t + k, k < B, k < B, 1, 1);
      end
      mark(t + B + 1, 0, 0, 0, 1);
    end else begin
      mark(t + 1, 1, 1, 0, 1);
      for (int k = 2; k <= B + 1; k++) begin
        mark(t + k, k <= B, k <= B, 1, 1);
      end
      mark(t + B + 2, 0, 0, 0, 1);
    end
  endtask

  task automatic model_reset(input int r);
    for (int c = r + 1; c < MAXC; c++) begin
      e_ack[c] = 0; e_busy[c] = 0; e_oe[c] = 0; e_dqsoe[c] = 0;
    end
    err_m = 0;
  endtask

  task automatic check_cycle(input int c);
    logic [31:0] d;
    logic [3:0]  m;
    d = e_oe[c] ? wd[c-1] : 32'h0;
    m = e_oe[c] ? wm[c-1] : 4'hF;
    chk("data_ack", {31'b0, data_ack}, {31'b0, e_ack[c]});
    chk("busy",     {31'b0, busy},     {31'b0, e_busy[c]});
    chk("dq_oe",    {31'b0, dq_oe},    {31'b0, e_oe[c]});
    chk("dqs_oe",   {31'b0, dqs_oe},   {31'b0, e_dqsoe[c]});
    chk("dqs_rise", {31'b0, dqs_rise}, {31'b0, e_oe[c]});
    chk("dqs_fall", {31'b0, dqs_fall}, 32'h0);
    chk("dq_rise",  {16'b0, dq_rise},  {16'b0, d[31:16]});
    chk("dq_fall",  {16'b0, dq_fall},  {16'b0, d[15:0]});
    chk("dm_rise",  {30'b0, dm_rise},  {30'b0, m[3:2]});
    chk("dm_fall",  {30'b0, dm_fall},  {30'b0, m[1:0]});
  endtask

  // driver: one cycle, inputs applied after the edge, outputs checked at negedge
  task automatic step(input logic w, input logic r, input logic [31:0] d, input logic [3:0] m);
    @(posedge sys_clk);
    #1;
    cyc++;
    write = w; sys_rst = r; write_data = d; write_mask = m;
    wd[cyc] = d; wm[cyc] = m;
    if (r) model_reset(cyc);
    else if (w) model_write(cyc);
    @(negedge sys_clk);
    if (chk_en) check_cycle(cyc);
  endtask

  task automatic step_r(input logic w);
    step(w, 1'b0, $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic chk_err;
`ifdef HPDMC_WRDATAPATH_ERRCNT_EN
    chk("err_count", {16'b0, err_count}, err_m);
`endif
  endtask

  initial begin
    // reset
    step(0, 1, 0, 0);
    chk_en = 1'b1;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step_r(0); step_r(0);

    // single write with beats A5A5_0001..0004
    step(1, 0, 32'hA5A5_0000, 4'h0);
    for (int k = 1; k <= 8; k++) step(0, 0, {16'hA5A5, 16'(k)}, 4'h0);

    // seamless chaining on the last beat
    step_r(1);
    for (int k = 1; k <= 4; k++) step_r(0);
    step_r(1);
    for (int k = 0; k < 8; k++) step_r(0);

    // write during the postamble
    step_r(1);
    for (int k = 1; k <= 5; k++) step_r(0);
    step_r(1);
    for (int k = 0; k < 8; k++) step_r(0);

    // write while busy (cnt=1) is ignored
    step_r(1);
    step_r(0); step_r(0);
    step_r(1);
    for (int k = 0; k < 6; k++) step_r(0);
    chk_err();

    // mask pattern 4'b0110 on the second beat
    step(1, 0, $urandom, 4'h0);
    step(0, 0, $urandom, 4'h0);
    step(0, 0, $urandom, 4'b0110);
    for (int k = 0; k < 6; k++) step(0, 0, $urandom, 4'h0);

    // reset mid-burst at cnt=2, then a clean burst
    step_r(1);
    for (int k = 1; k <= 3; k++) step_r(0);
    step(0, 1, $urandom, 4'h0);
    step_r(0); step_r(0);
    chk_err();
    step_r(1);
    for (int k = 0; k < 8; k++) step_r(0);

    // randomized write pulses
    for (int k = 0; k < 300; k++) step_r($urandom_range(0, 3) == 0);
    for (int k = 0; k < 8; k++) step_r(0);
    chk_err();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
